// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds the feeder FSM encoding and the lane-slice function.
package systolic_pkg;

    localparam int MAX_N_SIZE    = 16;
    localparam int MAX_DATAWIDTH = 32;
    localparam int LANE_VEC_W    = MAX_N_SIZE * MAX_N_SIZE * MAX_DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        FLUSH    = 2'd2,
        WAIT_RES = 2'd3
    } feeder_state_e;

    // Callers zero-extend their vector and truncate the result to dw bits.
    function automatic logic [MAX_DATAWIDTH-1:0] lane(
        input logic [LANE_VEC_W-1:0] vec,
        input int                    i,
        input int                    dw
    );
        logic [MAX_DATAWIDTH-1:0] mask;
        mask = {MAX_DATAWIDTH{1'b1}} >> (MAX_DATAWIDTH - dw);
        return MAX_DATAWIDTH'(vec >> (i * dw)) & mask;
    endfunction

endpackage

// File: rtl/systolic_mat_store.sv
// Captured A/B matrix registers for the feeder.
// Presents column k of A and row k of B as packed lane vectors.
module systolic_mat_store
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3,
    parameter int KW        = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  mat_a,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  mat_b,
    input  logic [KW-1:0]                       k,
    output logic [N_SIZE*DATAWIDTH-1:0]         col_a,
    output logic [N_SIZE*DATAWIDTH-1:0]         row_b
);

    localparam int MW = N_SIZE * N_SIZE * DATAWIDTH;

    logic [MW-1:0] a_q;
    logic [MW-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= mat_a;
            b_q <= mat_b;
        end
    end

    // Lane i carries A[i][k] and B[k][i].
    for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
        assign col_a[i*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(
            lane(LANE_VEC_W'(a_q), i * N_SIZE + int'(k), DATAWIDTH));
        assign row_b[i*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(
            lane(LANE_VEC_W'(b_q), int'(k) * N_SIZE + i, DATAWIDTH));
    end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit-side feeder: stores one A/B pair, streams it into the
// systolic array, then counts result rows before accepting the next pair.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH    = 16,
    parameter int N_SIZE       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0] s_mat_a,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0] s_mat_b,
    output logic                               arr_valid,
    output logic [N_SIZE*DATAWIDTH-1:0]        arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]        arr_b,
    input  logic                               arr_c_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int KW = $clog2(N_SIZE);
    localparam int RW = $clog2(N_SIZE + 1);
    localparam int FW = $clog2(N_SIZE + 1);

    localparam logic [KW-1:0] K_LAST   = KW'(N_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(N_SIZE - 1);
    localparam logic [FW-1:0] F_LAST   =
        FW'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

    feeder_state_e state;

    logic [KW-1:0]              k;
    logic [RW-1:0]              row_cnt;
    logic [FW-1:0]              f_cnt;
    logic [N_SIZE*DATAWIDTH-1:0] col_a;
    logic [N_SIZE*DATAWIDTH-1:0] row_b;
    logic                       accept;
    logic                       last_row;

    assign accept   = (state == IDLE) && s_valid && s_ready;
    assign last_row = arr_c_valid && (state != IDLE) &&
                      (row_cnt == ROW_LAST);

    systolic_mat_store #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .KW        (KW)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .mat_a (s_mat_a),
        .mat_b (s_mat_b),
        .k     (k),
        .col_a (col_a),
        .row_b (row_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            row_cnt   <= '0;
            f_cnt     <= '0;
            s_ready   <= 1'b1;
            arr_valid <= 1'b0;
            arr_a     <= '0;
            arr_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            // The final result row wins over any remaining input cycles.
            if (last_row) begin
                state     <= IDLE;
                row_cnt   <= '0;
                done      <= 1'b1;
                s_ready   <= 1'b1;
                busy      <= 1'b0;
                arr_valid <= 1'b0;
                arr_a     <= '0;
                arr_b     <= '0;
            end else begin
                if (arr_c_valid && (state != IDLE)) begin
                    row_cnt <= row_cnt + RW'(1);
                end
                unique case (state)
                    IDLE: begin
                        arr_valid <= 1'b0;
                        arr_a     <= '0;
                        arr_b     <= '0;
                        if (arr_c_valid) begin
                            err <= 1'b1;
                        end
                        if (accept) begin
                            state   <= STREAM;
                            k       <= '0;
                            row_cnt <= '0;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    STREAM: begin
                        arr_valid <= 1'b1;
                        arr_a     <= col_a;
                        arr_b     <= row_b;
                        if (k == K_LAST) begin
                            k     <= '0;
                            f_cnt <= '0;
                            state <= (FLUSH_CYCLES > 0) ? FLUSH : WAIT_RES;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                    FLUSH: begin
                        arr_valid <= 1'b1;
                        arr_a     <= '0;
                        arr_b     <= '0;
                        if (f_cnt == F_LAST) begin
                            state <= WAIT_RES;
                        end else begin
                            f_cnt <= f_cnt + FW'(1);
                        end
                    end
                    WAIT_RES: begin
                        arr_valid <= 1'b0;
                        arr_a     <= '0;
                        arr_b     <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side front end for the NxN systolic array.
- Accepts one complete A and B matrix pair through a valid/ready handshake and stores both.
- Streams them into the array's input port in the array's skew-free protocol: column k of A and row k of B on cycle k, then zero-data flush cycles.
- Counts the array's result-row strobes and signals completion, so the next matrix pair never overlaps the previous one inside the array.

Parameters:
- DATAWIDTH, 16, width of one matrix element (unsigned).
- N_SIZE, 3, matrix dimension N; legal range 2..16.
- FLUSH_CYCLES, 2, zero-data cycles with arr_valid held high after the last column/row; legal range 0..N_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream matrix pair valid.
- s_ready  out  1  feeder can accept a pair.
- s_mat_a  in  N_SIZE*N_SIZE*DATAWIDTH  matrix A, row-major; A[r][c] at bits ((r*N_SIZE+c)+1)*DATAWIDTH-1 -: DATAWIDTH.
- s_mat_b  in  N_SIZE*N_SIZE*DATAWIDTH  matrix B, same packing.
- arr_valid  out  1  drives the array's valid_in.
- arr_a  out  N_SIZE*DATAWIDTH  drives matrix_a_in; lane r = A[r][k].
- arr_b  out  N_SIZE*DATAWIDTH  drives matrix_b_in; lane c = B[k][c].
- arr_c_valid  in  1  the array's valid_out (one pulse per result row).
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the N-th result row has been seen.
- err  out  1  sticky: a result strobe arrived while in IDLE; cleared only by reset.

Behaviour:
- All outputs are registered.
- Reset values (async, rst_n=0): s_ready=1, arr_valid=0, arr_a=0, arr_b=0, busy=0, done=0, err=0, FSM=IDLE, k=0, row_cnt=0. Reset mid-stream discards the stored matrices; no partial output is resumed.
- Lane packing: lane i occupies bits (i+1)*DATAWIDTH-1 -: DATAWIDTH, lane 0 in the LSBs.
- FSM states: IDLE, STREAM, FLUSH, WAIT_RES.
- IDLE:
  - s_ready=1, arr_valid=0, arr_a=0, arr_b=0.
  - On s_valid&&s_ready: capture s_mat_a/s_mat_b, k=0, row_cnt=0, s_ready<=0, go to STREAM.
- STREAM:
  - Each cycle: arr_valid=1, arr_a = column k of A, arr_b = row k of B.
  - The first column/row appears on the clock edge after the accept edge (1-cycle latency).
  - k increments every cycle with no stalls.
  - After k==N_SIZE-1 is driven: go to FLUSH if FLUSH_CYCLES>0, else WAIT_RES.
- FLUSH: arr_valid=1, arr_a=0, arr_b=0 for exactly FLUSH_CYCLES cycles, then go to WAIT_RES.
- WAIT_RES: arr_valid=0, data=0; wait for the remaining result strobes.
- Result counting:
  - row_cnt (clog2(N_SIZE+1) bits) increments on every arr_c_valid seen in STREAM, FLUSH or WAIT_RES.
  - When the increment brings row_cnt to N_SIZE: done=1 for one cycle, row_cnt=0, FSM goes to IDLE and s_ready rises on that same edge, regardless of current state.
  - If that happens in STREAM or FLUSH, the remaining input cycles are abandoned.
  - Excess arr_c_valid in IDLE: no count, err<=1.
- Back-to-back operation: the earliest next accept is the cycle after done. s_valid held high during busy is ignored with no capture, and s_ready=0 throughout.
- s_mat_a/s_mat_b need only be stable on the accept edge.

Decomposition:
- Shared package systolic_pkg holds:
  - feeder_state_e enum (IDLE, STREAM, FLUSH, WAIT_RES);
  - lane-slice helper function lane(vec, i, DATAWIDTH);
  - the MAX_N_SIZE=16 constant.
- One natural sub-module, systolic_mat_store: holds the captured A/B registers and muxes out column k / row k given the index.
- The FSM, counters and flags stay in the top module.

Test Plan:
- Reset/idle: assert rst_n=0 mid-STREAM -> all outputs at reset values immediately (async); after release, s_ready=1, busy=0.
- Basic stream, N=2, FLUSH=2, A=[[2,1],[5,7]], B=[[4,2],[8,5]]:
  - arr_a = {5,2} then {7,1}, then 0,0; arr_b = {2,4} then {5,8}, then 0,0;
  - arr_valid high exactly 4 cycles starting 1 cycle after accept.
- Completion: after the stream, pulse arr_c_valid twice (gap 1 cycle) -> done is a single-cycle pulse on the edge of the 2nd strobe; s_ready=1 on that edge.
- Back-to-back: hold s_valid=1 continuously with a second pair A=[[7,9],[2,6]], B=[[3,2],[8,5]] -> no capture while busy; second accept happens the cycle after done; arr_a first = {2,7}.
- Stray strobe: arr_c_valid in IDLE -> err=1 and stays high; row_cnt unchanged; the next transaction still completes normally.
- FLUSH_CYCLES=0, N=3 -> arr_valid high exactly 3 cycles; an early 3rd strobe arriving during STREAM returns the FSM to IDLE with done.
